rapid_scoreboard_unit: RTL

Parametrised hazard/scoreboard unit for the rapid_x pipeline. It replaces the fixed single-stage forwarding path with a scoreboard of in-flight register writes across NUM_STAGES post-decode stages. It also tracks one multi-cycle execution unit (div/mul). Per decode-stage read port it generates a decode stall, registered forwarding selects for the execute stage, and multi-cycle busy/done status. It sits beside the decoder/execute state registers and is driven by the pipeline-advance (memory-ready) and branch-flush signals.

---
 rtl/rapid_scoreboard_unit_if.sv | 42 ++++
 rtl/rapid_scoreboard_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rapid_scoreboard_unit_if.sv
// Signal bundle between the rapid_x decode/execute stages and the scoreboard.
// Latency: none (wires only).
// Backpressure: o_stall holds decode; the pipeline side owns i_advance and i_flush.
// Ports: master = pipeline (drives i_*, reads o_*), slave = scoreboard.
//   i_rs packs port p at [p*RW +: RW]; o_fwd_sel packs port p at [p*SEL_W +: SEL_W].
interface rapid_scoreboard_unit_if #(
  parameter int NUM_REGS     = 32,
  parameter int NUM_STAGES   = 3,
  parameter int NUM_RD_PORTS = 2,
  parameter int SEL_W        = $clog2(NUM_STAGES) + 1,
  parameter int LAT_W        = 5
);
  localparam int RW = $clog2(NUM_REGS);

  logic                          i_advance;
  logic                          i_flush;
  logic                          i_issue_valid;
  logic [NUM_RD_PORTS*RW-1:0]    i_rs;
  logic [NUM_RD_PORTS-1:0]       i_rs_used;
  logic [RW-1:0]                 i_rd;
  logic                          i_rd_we;
  logic [SEL_W-1:0]              i_rdy_at;
  logic                          i_mc_op;
  logic [LAT_W-1:0]              i_mc_lat;
  logic                          o_stall;
  logic [NUM_RD_PORTS*SEL_W-1:0] o_fwd_sel;
  logic                          o_mc_busy;
  logic                          o_mc_done;
  logic [RW-1:0]                 o_mc_rd;

  modport master (
    output i_advance, i_flush, i_issue_valid, i_rs, i_rs_used, i_rd, i_rd_we,
           i_rdy_at, i_mc_op, i_mc_lat,
    input  o_stall, o_fwd_sel, o_mc_busy, o_mc_done, o_mc_rd
  );

  modport slave (
    input  i_advance, i_flush, i_issue_valid, i_rs, i_rs_used, i_rd, i_rd_we,
           i_rdy_at, i_mc_op, i_mc_lat,
    output o_stall, o_fwd_sel, o_mc_busy, o_mc_done, o_mc_rd
  );
endinterface

// File: rtl/rapid_scoreboard_unit.sv
// Scoreboard of in-flight register writes plus one multi-cycle unit; yields stall and forward selects.
// Latency: o_stall combinational from decode inputs; o_fwd_sel/mc state registered on the advance edge.
// Backpressure: o_stall holds decode and bubbles EX; i_advance=0 freezes slots, selects and new mc issue.
// Ports: i_clk, i_reset_n (async active-low) plus the slave side of rapid_scoreboard_unit_if.
module rapid_scoreboard_unit #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_STAGES   = 3,
  parameter int NUM_RD_PORTS = 2,
  parameter int SEL_W        = $clog2(NUM_STAGES) + 1,
  parameter int LAT_W        = 5
) (
  input logic                    i_clk,
  input logic                    i_reset_n,
  rapid_scoreboard_unit_if.slave sb
);
  localparam int RW = $clog2(NUM_REGS);

  // The unit only handles register indices; the datapath width must at least hold one.
  if (XLEN < RW) begin : g_bad_xlen
    $error("rapid_scoreboard_unit: XLEN too small");
  end

  // Slot k holds the write in flight k stages past decode (slot 0 = EX).
  logic [NUM_STAGES-1:0]         slot_vld;
  logic [RW-1:0]                 slot_rd     [NUM_STAGES];
  logic [SEL_W-1:0]              slot_rdy_at [NUM_STAGES];

  logic [NUM_RD_PORTS*SEL_W-1:0] fwd_cand;
  logic [NUM_RD_PORTS*SEL_W-1:0] fwd_sel;
  logic [NUM_RD_PORTS-1:0]       port_haz;
  logic                          mc_haz;
  logic                          stall;
  logic                          issue_ok;
  logic [LAT_W-1:0]              mc_cnt;
  logic [RW-1:0]                 mc_rd;
  logic                          mc_busy;

  // Per read port: youngest matching slot decides between stall and forward.
  always_comb begin
    logic [RW-1:0]    rs;
    logic             hit;
    int               hit_k;
    logic [SEL_W-1:0] hit_rdy;
    rs       = '0;
    hit      = 1'b0;
    hit_k    = 0;
    hit_rdy  = '0;
    port_haz = '0;
    fwd_cand = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rs      = sb.i_rs[p*RW +: RW];
      hit     = 1'b0;
      hit_k   = 0;
      hit_rdy = '0;
      // Scan oldest to youngest so the youngest match overwrites.
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (slot_vld[k] && slot_rd[k] == rs) begin
          hit     = 1'b1;
          hit_k   = k;
          hit_rdy = slot_rdy_at[k];
        end
      end
      if (sb.i_rs_used[p] && rs != '0 && hit) begin
        // Result not produced before the reader reaches EX: stall.
        if (int'(hit_rdy) > hit_k)
          port_haz[p] = 1'b1;
        // A write about to retire goes through the write-first register file.
        else if (hit_k + 1 < NUM_STAGES)
          fwd_cand[p*SEL_W +: SEL_W] = SEL_W'(hit_k + 1);
      end
    end
  end

  assign mc_busy = (mc_cnt != '0);

  always_comb begin
    mc_haz = 1'b0;
    if (mc_busy) begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (sb.i_rs_used[p] && sb.i_rs[p*RW +: RW] == mc_rd)
          mc_haz = 1'b1;
      end
      if (sb.i_rd_we && sb.i_rd == mc_rd)
        mc_haz = 1'b1;
      if (sb.i_mc_op)
        mc_haz = 1'b1;
    end
  end

  assign stall    = sb.i_issue_valid & ~sb.i_flush & ((|port_haz) | mc_haz);
  assign issue_ok = sb.i_issue_valid & ~sb.i_flush & ~stall;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slot_vld <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        slot_rd[k]     <= '0;
        slot_rdy_at[k] <= '0;
      end
      fwd_sel <= '0;
      mc_cnt  <= '0;
      mc_rd   <= '0;
    end else begin
      // The mc countdown runs independently of pipeline advance.
      if (mc_busy)
        mc_cnt <= mc_cnt - LAT_W'(1);
      if (sb.i_advance) begin
        for (int k = NUM_STAGES - 1; k > 0; k--) begin
          slot_vld[k]    <= slot_vld[k-1];
          slot_rd[k]     <= slot_rd[k-1];
          slot_rdy_at[k] <= slot_rdy_at[k-1];
        end
        // mc results are tracked by mc_rd, not by a pipeline slot.
        slot_vld[0]    <= issue_ok & sb.i_rd_we & (sb.i_rd != '0) & ~sb.i_mc_op;
        slot_rd[0]     <= sb.i_rd;
        slot_rdy_at[0] <= sb.i_rdy_at;
        fwd_sel        <= issue_ok ? fwd_cand : '0;
        // Issue is blocked while busy, so this never collides with the decrement.
        if (issue_ok && sb.i_mc_op) begin
          mc_cnt <= sb.i_mc_lat;
          mc_rd  <= sb.i_rd;
        end
      end
    end
  end

  assign sb.o_stall   = stall;
  assign sb.o_fwd_sel = fwd_sel;
  assign sb.o_mc_busy = mc_busy;
  assign sb.o_mc_done = (mc_cnt == LAT_W'(1));
  assign sb.o_mc_rd   = mc_rd;
endmodule
